// File: rtl/sram_req_encoder.sv
// Round-robin N-to-log2(N) request encoder. Offers the winning index to an
// SRAM port over valid/ready and returns a one-cycle one-hot grant.
module sram_req_encoder #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N-1:0]      req,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      grant
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [N-1:0]        eligible;
  logic [ADDR_W-1:0]   sel;
  logic [ADDR_W-1:0]   idx;
  logic                found;

  // The bit granted this cycle is masked: its requester drops req one cycle late.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    eligible = req & ~grant;
    found    = 1'b0;
    sel      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + ADDR_W'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= 1'b0;
      addr  <= '0;
      grant <= '0;
      ptr   <= '0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (en && found) begin
            addr  <= sel;
            valid <= 1'b1;
            state <= OFFER;
          end
        end
        OFFER: begin
          // Offer is never retracted: req and en are ignored until ready.
          if (ready) begin
            grant <= {{(N-1){1'b0}}, 1'b1} << addr;
            ptr   <= addr + ADDR_W'(1);
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_encoder.sv
// Directed self-checking bench for sram_req_encoder: reset, single request,
// round robin, pointer wrap, backpressure and mid-offer reset.
module tb_sram_req_encoder;

  localparam int N      = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [N-1:0]      req;
  logic              ready;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [N-1:0]      grant;

  int checks;
  int errors;

  sram_req_encoder #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .ready (ready),
    .valid (valid),
    .addr  (addr),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic exp_valid,
                            input logic [ADDR_W-1:0] exp_addr,
                            input logic [N-1:0] exp_grant);
    checks++;
    if (valid !== exp_valid) begin
      errors++;
      $display("FAIL %s valid got %0b want %0b", name, valid, exp_valid);
    end
    checks++;
    if (exp_valid && addr !== exp_addr) begin
      errors++;
      $display("FAIL %s addr got %0d want %0d", name, addr, exp_addr);
    end
    checks++;
    if (grant !== exp_grant) begin
      errors++;
      $display("FAIL %s grant got 0x%08h want 0x%08h", name, grant, exp_grant);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    ready = 1'b1;
    req   = '1;
    #3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || addr !== '0 || grant !== '0) begin
        errors++;
        $display("FAIL reset cycle %0d valid=%0b addr=%0d grant=0x%08h want 0/0/0",
                 i, valid, addr, grant);
      end
    end
    req = '0;
    #2;
    rst_n = 1'b1;
    tick();
    expect_out("reset_release", 1'b0, '0, '0);
  endtask

  task automatic test_single();
    req = 32'h0000_0020;
    tick(); expect_out("single_offer", 1'b1, 5'd5, '0);
    tick(); expect_out("single_grant", 1'b0, 5'd0, 32'h0000_0020);
    // Requester still holds req this cycle; the grant mask keeps it out.
    tick(); expect_out("single_masked", 1'b0, 5'd0, '0);
    req = '0;
    // ptr should now be 6: with bits 5 and 6 pending, 6 wins.
    req = 32'h0000_0060;
    tick(); expect_out("ptr6_offer", 1'b1, 5'd6, '0);
    tick(); expect_out("ptr6_grant", 1'b0, 5'd0, 32'h0000_0040);
    req = 32'h0000_0020;
    tick(); expect_out("ptr7_wrap_offer", 1'b1, 5'd5, '0);
    tick(); expect_out("ptr7_wrap_grant", 1'b0, 5'd0, 32'h0000_0020);
    req = '0;
    tick(); expect_out("single_idle", 1'b0, 5'd0, '0);
  endtask

  task automatic test_round_robin();
    apply_reset();
    req = (32'd1 << 3) | (32'd1 << 20);
    tick(); expect_out("rr_offer3", 1'b1, 5'd3, '0);
    tick(); expect_out("rr_grant3", 1'b0, 5'd0, 32'h0000_0008);
    req = 32'd1 << 20;
    tick(); expect_out("rr_offer20", 1'b1, 5'd20, '0);
    req = (32'd1 << 3) | (32'd1 << 20);
    tick(); expect_out("rr_grant20", 1'b0, 5'd0, 32'h0010_0000);
    req = 32'd1 << 3;
    tick(); expect_out("rr_offer3b", 1'b1, 5'd3, '0);
    tick(); expect_out("rr_grant3b", 1'b0, 5'd0, 32'h0000_0008);
    req = '0;
    tick(); expect_out("rr_idle", 1'b0, 5'd0, '0);
  endtask

  task automatic test_wrap();
    // Granting bit 30 leaves ptr at 31.
    req = 32'd1 << 30;
    tick(); expect_out("wrap_pre_offer", 1'b1, 5'd30, '0);
    tick(); expect_out("wrap_pre_grant", 1'b0, 5'd0, 32'h4000_0000);
    req = '0;
    tick();
    req = (32'd1 << 31) | 32'd1;
    tick(); expect_out("wrap_offer31", 1'b1, 5'd31, '0);
    tick(); expect_out("wrap_grant31", 1'b0, 5'd0, 32'h8000_0000);
    req = 32'd1;
    tick(); expect_out("wrap_offer0", 1'b1, 5'd0, '0);
    tick(); expect_out("wrap_grant0", 1'b0, 5'd0, 32'h0000_0001);
    // ptr should be 1: bit 1 beats bit 0.
    req = 32'h0000_0003;
    tick(); expect_out("wrap_ptr1_offer", 1'b1, 5'd1, '0);
    tick(); expect_out("wrap_ptr1_grant", 1'b0, 5'd0, 32'h0000_0002);
    req = '0;
    tick(); expect_out("wrap_idle", 1'b0, 5'd0, '0);
  endtask

  task automatic test_en_gate();
    en  = 1'b0;
    req = 32'h0000_0100;
    tick(); expect_out("en_low_idle_a", 1'b0, 5'd0, '0);
    tick(); expect_out("en_low_idle_b", 1'b0, 5'd0, '0);
    req = '0;
    en  = 1'b1;
    tick(); expect_out("req_zero_idle", 1'b0, 5'd0, '0);
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    req   = 32'h0000_0080;
    tick(); expect_out("bp_offer", 1'b1, 5'd7, '0);
    en  = 1'b0;
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out($sformatf("bp_hold%0d", i), 1'b1, 5'd7, '0);
    end
    ready = 1'b1;
    tick(); expect_out("bp_grant", 1'b0, 5'd0, 32'h0000_0080);
    tick(); expect_out("bp_after", 1'b0, 5'd0, '0);
    en = 1'b1;
  endtask

  task automatic test_mid_offer_reset();
    // ptr is 8 here, so bit 9 wins first; after reset ptr=0 makes bit 3 win.
    ready = 1'b0;
    req   = (32'd1 << 9) | (32'd1 << 3);
    tick(); expect_out("mor_offer9", 1'b1, 5'd9, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || addr !== '0 || grant !== '0) begin
      errors++;
      $display("FAIL mor_async valid=%0b addr=%0d grant=0x%08h want 0/0/0",
               valid, addr, grant);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL mor_in_reset valid=%0b grant=0x%08h want 0/0", valid, grant);
    end
    #2;
    rst_n = 1'b1;
    tick(); expect_out("mor_reoffer3", 1'b1, 5'd3, '0);
    tick(); expect_out("mor_grant3", 1'b0, 5'd0, 32'h0000_0008);
    req = '0;
    tick(); expect_out("mor_idle", 1'b0, 5'd0, '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    req    = '0;
    ready  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_en_gate();
    test_backpressure();
    test_mid_offer_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
